// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply / divide engine: radix-2 Booth multiply and restoring
// divide on shared working registers, one iteration per clock, WIDTH iterations.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic             w_accept;
  logic             w_dz_hit;

  logic             r_op;
  logic [CW-1:0]    r_cnt;
  // r_acc doubles as Booth accumulator (multiply) and partial remainder (divide);
  // r_q is the multiplier shift register or the quotient being built.
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH:0]   r_m;
  logic             r_sa;
  logic             r_sb;

  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic; a divide by zero completes without leaving IDLE.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_dz_hit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (op && (b == {WIDTH{1'b0}})) begin
            w_dz_hit  = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_accept  = 1'b1;
            w_state_n = ST_RUN;
          end
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_n = ST_FIX;
        end else begin
          w_state_n = ST_RUN;
        end
      end
      ST_FIX:  w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Booth recoding of the {q[0], q-1} pair selects add, subtract or pass.
  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_booth_sum = r_acc + r_m;
      2'b10:   w_booth_sum = r_acc - r_m;
      default: w_booth_sum = r_acc;
    endcase
  end

  assign w_rem_sh   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial    = w_rem_sh - r_m;
  assign w_abs_a    = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
  assign w_abs_b    = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
  assign w_quot_fix = (r_sa ^ r_sb) ? ({WIDTH{1'b0}} - r_q) : r_q;
  assign w_rem_fix  = r_sa ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];

  // Working registers: load on accept, one Booth or restoring step per RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op  <= 1'b0;
      r_cnt <= {CW{1'b0}};
      r_acc <= {(WIDTH + 1){1'b0}};
      r_q   <= {WIDTH{1'b0}};
      r_q1  <= 1'b0;
      r_m   <= {(WIDTH + 1){1'b0}};
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
    end else if (w_accept) begin
      r_op  <= op;
      r_cnt <= {CW{1'b0}};
      r_acc <= {(WIDTH + 1){1'b0}};
      r_q1  <= 1'b0;
      r_sa  <= a[WIDTH-1];
      r_sb  <= b[WIDTH-1];
      if (op) begin
        r_q <= w_abs_a;
        r_m <= {1'b0, w_abs_b};
      end else begin
        r_q <= b;
        r_m <= {a[WIDTH-1], a};
      end
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_op) begin
        if (!w_trial[WIDTH]) begin
          r_acc <= w_trial;
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_rem_sh;
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
        r_q1  <= r_q[0];
      end
    end
  end

  // Result and status registers; busy follows the next state so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
    end else begin
      r_busy <= (w_state_n != ST_IDLE);
      r_done <= (r_state == ST_FIX) || w_dz_hit;
      if (w_dz_hit) begin
        r_dz <= 1'b1;
      end else if (w_accept) begin
        r_dz <= 1'b0;
      end
      if (r_state == ST_FIX) begin
        if (r_op) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quot_fix;
        end else begin
          r_hi <= r_acc[WIDTH-1:0];
          r_lo <= r_q;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, corner-case
// sequences and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic; SV division truncates toward zero.
  task automatic model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa;
    longint sb;
    longint p;
    sa = $signed(a_i);
    sb = $signed(b_i);
    if (!op_i) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else begin
      p  = sa / sb;
      el = p[31:0];
      p  = sa % sb;
      eh = p[31:0];
    end
  endtask

  // Issue one operation at a negedge, optionally poke a second start mid-run,
  // and check latency, busy, held results and final values.
  task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] eh, input logic [31:0] el,
                        input string nm, input int poke);
    int n;
    bit bad;
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(negedge clk);
    n = 0;
    bad = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) bad = 1'b1;
      start = (n == poke);
      op = 1'($urandom);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({"latency ", nm}, 64'(n), 64'd33);
    chk({"busy/hold ", nm}, 64'(bad), 64'd0);
    chk({"busy at done ", nm}, 64'(busy), 64'd0);
    chk({"hi ", nm}, 64'(hi), 64'(eh));
    chk({"lo ", nm}, 64'(lo), 64'(el));
    chk({"div_zero ", nm}, 64'(div_zero), 64'd0);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] eh;
    logic [31:0] el;
    logic        rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;

    vecs[0] = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mul 7*-3"};
    vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mul min*min"};
    vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
    vecs[4] = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "div 100/7"};
    vecs[5] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, "div -100/-7"};
    vecs[6] = '{1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, "div 100/-7"};
    vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mul -1*-1"};
    vecs[8] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, "mul max*max"};
    vecs[9] = '{1'b1, 32'h00002211, 32'h00000100, 32'h00000011, 32'h00000022, "div to 11/22"};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 32'h0; b = 32'h0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each next start is driven in the cycle done is high.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name, -1);
    end

    // Divide by zero with hi=0x11, lo=0x22 left by the last vector.
    start = 1'b1; op = 1'b1; a = 32'h5; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    chk("dz done", 64'(done), 64'd1);
    chk("dz flag", 64'(div_zero), 64'd1);
    chk("dz busy", 64'(busy), 64'd0);
    chk("dz hi/lo held", {hi, lo}, 64'h00000011_00000022);
    @(negedge clk);
    chk("dz done pulse", 64'(done), 64'd0);
    chk("dz sticky", 64'(div_zero), 64'd1);
    chk("dz busy stays low", 64'(busy), 64'd0);

    // Second start at cycle 5 is ignored; also clears div_zero on accept.
    run_op(1'b0, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFD44, "mul ignore restart", 5);

    // Reset in the middle of a multiply.
    start = 1'b1; op = 1'b0; a = 32'h12345; b = 32'h6789;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi/lo", {hi, lo}, 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) n++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) n++;
    end
    chk("no done after reset", 64'(n), 64'd0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, "mul 3*4", -1);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom);
      ra  = (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 400)) - 200);
      rb  = (i % 3 == 0) ? $urandom : 32'($signed($urandom_range(0, 60)) - 30);
      if (rop && rb == 32'h0) rb = 32'h3;
      model(rop, ra, rb, eh, el);
      run_op(rop, ra, rb, eh, el, $sformatf("rand%0d", i), (i % 4 == 0) ? 7 : -1);
    end

    @(negedge clk);
    chk("final done pulse", 64'(done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
